// File: rtl/sipo_framed_if.sv
// Handshake bundle between the serial front end and the sipo_framed deserialiser.
interface sipo_framed_if #(
  parameter int SIZE = 8
);
  logic            data_in;
  logic            en_in;
  logic            sync_in;
  logic            ready_in;
  logic [SIZE-1:0] data_out;
  logic            valid_out;
  logic            busy_out;
  logic            overrun_out;
  logic            parity_err_out;

  modport master (
    output data_in, en_in, sync_in, ready_in,
    input  data_out, valid_out, busy_out, overrun_out, parity_err_out
  );

  modport slave (
    input  data_in, en_in, sync_in, ready_in,
    output data_out, valid_out, busy_out, overrun_out, parity_err_out
  );
endinterface

// File: rtl/sipo_framed.sv
// Serial-to-parallel frame assembler with held output word, valid/ready handshake and sticky overrun.
// Optional trailing parity bit per frame is enabled by defining SIPO_PARITY_EN.
module sipo_framed #(
  parameter int SIZE       = 8,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic         clk_in,
  input logic         rst_n_in,
  sipo_framed_if.slave bus
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = SIZE + 1;
`else
  localparam int FRAME = SIZE;
`endif
  localparam int CNT_W = $clog2(FRAME);

  function automatic logic parity_err(input logic [SIZE:0] v);
    return (^v) != (PARITY_ODD != 0);
  endfunction

  logic [SIZE-1:0]  r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [SIZE-1:0]  r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             r_perr;

  logic             w_take;
  logic             w_at_last;
  logic             w_done;
  logic             w_consume;
  logic             w_shift_en;
  logic [SIZE-1:0]  w_sh_next;
  logic [SIZE-1:0]  w_word;
  logic             w_perr;
  logic [CNT_W-1:0] w_cnt_next;

  // Sync outranks the bit strobe: a strobe in the sync cycle is dropped.
  assign w_take    = bus.en_in & ~bus.sync_in;
  assign w_at_last = (r_cnt == CNT_W'(FRAME - 1));
  assign w_done    = w_take & w_at_last;
  assign w_consume = r_valid & bus.ready_in;
  assign w_sh_next = (MSB_FIRST != 0) ? {r_sh[SIZE-2:0], bus.data_in}
                                      : {bus.data_in, r_sh[SIZE-1:1]};

`ifdef SIPO_PARITY_EN
  // The parity bit is the last one in; it is checked but never shifted into the word.
  assign w_word     = r_sh;
  assign w_perr     = parity_err({r_sh, bus.data_in});
  assign w_shift_en = w_take & ~w_at_last;
`else
  assign w_word     = w_sh_next;
  assign w_perr     = 1'b0;
  assign w_shift_en = w_take;
`endif

  always_comb begin
    w_cnt_next = r_cnt;
    if (bus.sync_in)
      w_cnt_next = '0;
    else if (bus.en_in)
      w_cnt_next = w_at_last ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_sh      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_busy <= (w_cnt_next != '0);
      if (bus.sync_in)
        r_sh <= '0;
      else if (w_shift_en)
        r_sh <= w_sh_next;

      // A completing frame may replace the held word only if that word leaves this edge.
      if (w_done) begin
        if (!r_valid || w_consume) begin
          r_data  <= w_word;
          r_perr  <= w_perr;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out       = r_data;
  assign bus.valid_out      = r_valid;
  assign bus.busy_out       = r_busy;
  assign bus.overrun_out    = r_overrun;
  assign bus.parity_err_out = r_perr;

endmodule

// File: tb/tb_sipo_framed.sv
// Bench for sipo_framed: an MSB-first and an LSB-first instance driven by one serial stream,
// with a per-instance expected-word queue drained by handshake monitors.
module tb_sipo_framed;
  localparam int SIZE = 8;

  logic clk;
  logic rst_n;
  logic d_data, d_en, d_sync, d_ready;

  int n_pass  = 0;
  int n_total = 0;

  logic [SIZE-1:0] q_m[$];
  logic [SIZE-1:0] q_l[$];

  sipo_framed_if #(.SIZE(SIZE)) if_m ();
  sipo_framed_if #(.SIZE(SIZE)) if_l ();

  assign if_m.data_in  = d_data;
  assign if_m.en_in    = d_en;
  assign if_m.sync_in  = d_sync;
  assign if_m.ready_in = d_ready;
  assign if_l.data_in  = d_data;
  assign if_l.en_in    = d_en;
  assign if_l.sync_in  = d_sync;
  assign if_l.ready_in = d_ready;

  sipo_framed #(.SIZE(SIZE), .MSB_FIRST(1), .PARITY_ODD(0)) dut_m (
    .clk_in(clk), .rst_n_in(rst_n), .bus(if_m.slave));
  sipo_framed #(.SIZE(SIZE), .MSB_FIRST(0), .PARITY_ODD(0)) dut_l (
    .clk_in(clk), .rst_n_in(rst_n), .bus(if_l.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitors: a word is checked against the queue at the moment it is handed over.
  always @(negedge clk) begin
    if (rst_n && if_m.valid_out && if_m.ready_in) begin
      if (q_m.size() == 0) chk("m_underflow", 32'(q_m.size()), 32'd1);
      else chk("m_word", 32'(if_m.data_out), 32'(q_m.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_l.valid_out && if_l.ready_in) begin
      if (q_l.size() == 0) chk("l_underflow", 32'(q_l.size()), 32'd1);
      else chk("l_word", 32'(if_l.data_out), 32'(q_l.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    d_en = 1'b1; d_data = b; d_ready = rdy;
    tick();
    d_en = 1'b0; d_ready = 1'b0;
  endtask

  // Sends w MSB first; with parity enabled a trailing parity bit follows.
  task automatic send_word(input logic [SIZE-1:0] w, input logic par, input logic rdy_last);
    for (int i = SIZE - 1; i >= 0; i--) begin
`ifdef SIPO_PARITY_EN
      send_bit(w[i], 1'b0);
`else
      send_bit(w[i], (i == 0) ? rdy_last : 1'b0);
`endif
    end
`ifdef SIPO_PARITY_EN
    send_bit(par, rdy_last);
`endif
  endtask

  task automatic expect_word(input logic [SIZE-1:0] wm, input logic [SIZE-1:0] wl);
    q_m.push_back(wm);
    q_l.push_back(wl);
  endtask

  task automatic check_held(input string name, input logic [SIZE-1:0] wm, input logic [SIZE-1:0] wl);
    chk({name, "_m_valid"}, 32'(if_m.valid_out), 32'd1);
    chk({name, "_m_data"},  32'(if_m.data_out),  32'(wm));
    chk({name, "_l_valid"}, 32'(if_l.valid_out), 32'd1);
    chk({name, "_l_data"},  32'(if_l.data_out),  32'(wl));
  endtask

  task automatic consume(input string name);
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    chk({name, "_m_valid_clr"}, 32'(if_m.valid_out), 32'd0);
    chk({name, "_l_valid_clr"}, 32'(if_l.valid_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; d_data = 1'b0; d_en = 1'b0; d_sync = 1'b0; d_ready = 1'b0;

    // Reset held while bits stream in: every output stays zero.
    for (int i = 0; i < 4; i++) begin
      d_en = 1'b1; d_data = i[0];
      tick();
      chk("rst_m_outs", 32'({if_m.data_out, if_m.valid_out, if_m.busy_out,
                             if_m.overrun_out, if_m.parity_err_out}), 32'd0);
      chk("rst_l_outs", 32'({if_l.data_out, if_l.valid_out, if_l.busy_out,
                             if_l.overrun_out, if_l.parity_err_out}), 32'd0);
    end
    d_en = 1'b0;
    rst_n = 1'b1;
    tick();

    // Reset mid-frame discards the partial bits.
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    chk("partial_busy", 32'(if_m.busy_out), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(if_m.busy_out), 32'd0);

    // 1,0,1,0,0,1,0,1 is A5 in both bit orders.
    expect_word(8'hA5, 8'hA5);
    send_word(8'hA5, ^8'hA5, 1'b0);
    check_held("a5", 8'hA5, 8'hA5);
    chk("a5_busy", 32'(if_m.busy_out), 32'd0);
    consume("a5");

    // 1,1,0,0,0,0,0,0: C0 MSB-first, 03 LSB-first.
    expect_word(8'hC0, 8'h03);
    send_word(8'hC0, ^8'hC0, 1'b0);
    check_held("c0", 8'hC0, 8'h03);
    consume("c0");

    // Three stray bits, then sync with a strobe that must be dropped.
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    chk("pre_sync_busy", 32'(if_l.busy_out), 32'd1);
    d_sync = 1'b1;
    send_bit(1'b1, 1'b0);
    d_sync = 1'b0;
    chk("sync_m_busy", 32'(if_m.busy_out), 32'd0);
    chk("sync_l_busy", 32'(if_l.busy_out), 32'd0);
    expect_word(8'h3C, 8'h3C);
    send_word(8'h3C, ^8'h3C, 1'b0);
    check_held("3c", 8'h3C, 8'h3C);
    consume("3c");

    // Overrun: 22 arrives while 11 is held and is dropped.
    expect_word(8'h11, 8'h88);
    send_word(8'h11, ^8'h11, 1'b0);
    chk("ovr_before", 32'(if_m.overrun_out), 32'd0);
    send_word(8'h22, ^8'h22, 1'b0);
    check_held("drop22", 8'h11, 8'h88);
    chk("ovr_m", 32'(if_m.overrun_out), 32'd1);
    chk("ovr_l", 32'(if_l.overrun_out), 32'd1);

    // Consume 11 on the very edge that completes 33.
    expect_word(8'h33, 8'hCC);
    send_word(8'h33, ^8'h33, 1'b1);
    check_held("swap33", 8'h33, 8'hCC);
    consume("33");
    chk("ovr_sticky", 32'(if_m.overrun_out), 32'd1);

`ifdef SIPO_PARITY_EN
    expect_word(8'h01, 8'h80);
    send_word(8'h01, 1'b1, 1'b0);
    check_held("par_ok", 8'h01, 8'h80);
    chk("par_ok_err", 32'(if_m.parity_err_out), 32'd0);
    consume("par_ok");
    expect_word(8'h01, 8'h80);
    send_word(8'h01, 1'b0, 1'b0);
    check_held("par_bad", 8'h01, 8'h80);
    chk("par_bad_m_err", 32'(if_m.parity_err_out), 32'd1);
    chk("par_bad_l_err", 32'(if_l.parity_err_out), 32'd1);
    consume("par_bad");
`else
    chk("par_tied", 32'({if_m.parity_err_out, if_l.parity_err_out}), 32'd0);
`endif

    tick();
    chk("q_m_drained", 32'(q_m.size()), 32'd0);
    chk("q_l_drained", 32'(q_l.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
